// File: rtl/mult_pipe_hs_if.sv
// mult_pipe_hs_if: handshake bundle for the pipelined multiplier
//   request side : valid_i, ready_o, op_A_i, op_B_i, signed_A_i, signed_B_i, upper_i, tag_i
//   control      : flush_i kills all in-flight ops, busy_o reports any op in flight
//   response side: valid_o, ready_i, result_o, tag_o
//   master drives requests and consumes results; slave is the multiplier
interface mult_pipe_hs_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             valid_i;
    logic             ready_o;
    logic [XLEN-1:0]  op_A_i;
    logic [XLEN-1:0]  op_B_i;
    logic             signed_A_i;
    logic             signed_B_i;
    logic             upper_i;
    logic [TAG_W-1:0] tag_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;
    modport master (
        output valid_i, op_A_i, op_B_i, signed_A_i, signed_B_i, upper_i, tag_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, tag_o, busy_o
    );
    modport slave (
        input  valid_i, op_A_i, op_B_i, signed_A_i, signed_B_i, upper_i, tag_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, tag_o, busy_o
    );
endinterface

// File: rtl/mult_pipe_hs.sv
// mult_pipe_hs: RV32M/RV64M multiply unit, STAGES-deep accumulate pipeline plus output register
//   clk_i : rising-edge clock
//   rst_i : synchronous active-low reset
//   bus   : mult_pipe_hs_if.slave (operands, variant flags, tag, flush, result handshake, busy)
module mult_pipe_hs #(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input logic          clk_i,
    input logic          rst_i,
    mult_pipe_hs_if.slave bus
);
    localparam int W  = 2 * XLEN;
    localparam int C  = (XLEN + STAGES - 1) / STAGES;
    localparam int BW = C * STAGES;
    logic [STAGES-1:0] v_q, up_q;
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [W-1:0]      a_q   [STAGES];
    logic [W-1:0]      acc_q [STAGES];
    logic [W-1:0]      acc_d [STAGES];
    logic [BW-1:0]     b_q   [STAGES];
    logic [W-1:0]      a_se;
    logic [BW-1:0]     b_pad;
    logic              adv, valid_q;
    logic [XLEN-1:0]   res_q;
    logic [TAG_W-1:0]  tag_out_q;
    assign adv          = ~valid_q | bus.ready_i;
    assign bus.ready_o  = rst_i & adv;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = res_q;
    assign bus.tag_o    = tag_out_q;
    assign bus.busy_o   = |v_q | valid_q;
    // Operand A is sign/zero extended to 2*XLEN so the modular product needs no further fixup.
    assign a_se  = {{XLEN{bus.signed_A_i & bus.op_A_i[XLEN-1]}}, bus.op_A_i};
    assign b_pad = BW'(bus.op_B_i);
    // B_ext = B - sB*2^XLEN: the negative weight of B's sign bit is folded into the first stage,
    // the remaining unsigned B bits are consumed C at a time, one chunk per stage.
    always_comb begin
        acc_d[0] = a_se * W'(b_pad[C-1:0])
                 - ((bus.signed_B_i & bus.op_B_i[XLEN-1]) ? (a_se << XLEN) : '0);
        for (int k = 1; k < STAGES; k++)
            acc_d[k] = acc_q[k-1] + ((a_q[k-1] * W'(b_q[k-1][k*C +: C])) << (k * C));
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            v_q       <= '0;
            valid_q   <= 1'b0;
            res_q     <= '0;
            tag_out_q <= '0;
        end else if (bus.flush_i) begin
            v_q     <= '0;
            valid_q <= 1'b0;
        end else if (adv) begin
            v_q     <= (v_q << 1) | STAGES'(bus.valid_i);
            up_q    <= (up_q << 1) | STAGES'(bus.upper_i);
            valid_q <= v_q[STAGES-1];
            if (v_q[STAGES-1]) begin
                res_q     <= up_q[STAGES-1] ? acc_q[STAGES-1][W-1:XLEN] : acc_q[STAGES-1][XLEN-1:0];
                tag_out_q <= tag_q[STAGES-1];
            end
            if (bus.valid_i) begin
                a_q[0]   <= a_se;
                b_q[0]   <= b_pad;
                acc_q[0] <= acc_d[0];
                tag_q[0] <= bus.tag_i;
            end
            for (int k = 1; k < STAGES; k++) begin
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                acc_q[k] <= acc_d[k];
                tag_q[k] <= tag_q[k-1];
            end
        end
    end
endmodule

// File: tb/tb_mult_pipe_hs.sv
// tb_mult_pipe_hs: randomized + directed bench for mult_pipe_hs against an in-flight-queue model
module tb_mult_pipe_hs;
    localparam int S = 4;
    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          age;
    } op_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;
    op_t q[$];
    logic [31:0] exp_res = '0;
    logic [4:0]  exp_tag = '0;
    bit ev_m, adv_m, ev_c;
    mult_pipe_hs_if #(.XLEN(32), .TAG_W(5)) bus ();
    mult_pipe_hs #(.XLEN(32), .STAGES(S), .TAG_W(5)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb, input logic up);
        logic signed [65:0] p;
        p = $signed({{34{sa & a[31]}}, a}) * $signed({{34{sb & b[31]}}, b});
        return up ? p[63:32] : p[31:0];
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask
    // Model: each accepted op ages by one per advancing edge and is on the output at age S.
    always @(posedge clk) begin
        ev_m = q.size() > 0 && q[0].age >= S;
        if (!rst) begin
            q.delete();
            exp_res = '0;
            exp_tag = '0;
        end else begin
            adv_m = !ev_m || bus.ready_i;
            if (ev_m && bus.ready_i) void'(q.pop_front());
            if (bus.flush_i) q.delete();
            else if (adv_m) begin
                foreach (q[i]) begin
                    q[i].age++;
                    if (q[i].age == S) begin
                        exp_res = q[i].res;
                        exp_tag = q[i].tag;
                    end
                end
                if (bus.valid_i)
                    q.push_back('{golden(bus.op_A_i, bus.op_B_i, bus.signed_A_i, bus.signed_B_i,
                                         bus.upper_i), bus.tag_i, 0});
            end
        end
    end
    always @(negedge clk) begin
        if (chk_on) begin
            ev_c = q.size() > 0 && q[0].age >= S;
            chk("valid_o", {31'd0, bus.valid_o}, {31'd0, ev_c});
            chk("result_o", bus.result_o, exp_res);
            chk("tag_o", {27'd0, bus.tag_o}, {27'd0, exp_tag});
            chk("busy_o", {31'd0, bus.busy_o}, {31'd0, q.size() != 0});
            chk("ready_o", {31'd0, bus.ready_o}, {31'd0, rst && (!ev_c || bus.ready_i)});
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic set_op(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic up, input logic [4:0] t);
        bus.valid_i = v;
        bus.op_A_i = a;
        bus.op_B_i = b;
        bus.signed_A_i = sa;
        bus.signed_B_i = sb;
        bus.upper_i = up;
        bus.tag_i = t;
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sa,
                           input logic sb, input logic up, input logic [31:0] expv);
        int lat = 0;
        set_op(1'b1, a, b, sa, sb, up, 5'd7);
        cyc();
        bus.valid_i = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cyc();
            if (bus.valid_o) lat = i;
        end
        chk("latency", lat, S);
        chk("lit_result", bus.result_o, expv);
        cyc();
    endtask
    initial begin
        int n;
        int first;
        logic [4:0] tags [4];
        set_op(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        chk("pin_mul", golden(32'h8000_0001, 32'h8001_0002, 0, 0, 0), 32'h8001_0002);
        chk("pin_mulh", golden(32'h8000_0001, 32'h8001_0002, 1, 1, 1), 32'h3FFF_7FFE);
        chk("pin_mulhsu", golden(32'h8000_0001, 32'h8001_0002, 1, 0, 1), 32'hBFFF_7FFF);
        chk("pin_mulhu", golden(32'h8000_0001, 32'h8001_0002, 0, 0, 1), 32'h4000_8001);
        repeat (3) cyc();
        chk_on = 1'b1;
        chk("rst_ready_o", {31'd0, bus.ready_o}, 32'd0);
        chk("rst_valid_o", {31'd0, bus.valid_o}, 32'd0);
        chk("rst_busy_o", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_result_o", bus.result_o, 32'd0);
        rst = 1'b1;
        cyc();
        run_one(32'h8000_0001, 32'h8001_0002, 0, 0, 0, 32'h8001_0002);
        run_one(32'h8000_0001, 32'h8001_0002, 1, 1, 1, 32'h3FFF_7FFE);
        run_one(32'h8000_0001, 32'h8001_0002, 1, 0, 1, 32'hBFFF_7FFF);
        run_one(32'h8000_0001, 32'h8001_0002, 0, 0, 1, 32'h4000_8001);
        for (int t = 1; t <= 4; t++) begin
            set_op(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 5'(t));
            cyc();
        end
        bus.valid_i = 1'b0;
        n = 0;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (bus.valid_o) begin
                if (first < 0) first = i;
                if (n < 4) tags[n] = bus.tag_o;
                if (n == i - first) n++;
                else n = 100;
            end
        end
        chk("b2b_consecutive", n, 4);
        for (int t = 0; t < 4; t++) chk("b2b_tag", {27'd0, tags[t]}, t + 1);
        bus.ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_op(1'b1, pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_o", {31'd0, bus.ready_o}, 32'd0);
            cyc();
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (10) cyc();
        chk("bp_drained", {31'd0, bus.busy_o}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            set_op(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 5'(20 + i));
            cyc();
        end
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("flush_busy", {31'd0, bus.busy_o}, 32'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.valid_o) n++;
        end
        chk("flush_no_valid", n, 0);
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, $urandom, $urandom, 1'b1, 1'b1, 1'b0, 5'(i));
            cyc();
        end
        repeat (2) cyc();
        rst = 1'b0;
        bus.flush_i = 1'b1;
        cyc();
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("mid_rst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("mid_rst_result", bus.result_o, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        run_one(32'h8000_0001, 32'h8001_0002, 0, 0, 1, 32'h4000_8001);
        for (int i = 0; i < 1500; i++) begin
            set_op($urandom_range(0, 9) < 7, pick(), pick(), 1'($urandom), 1'($urandom),
                   1'($urandom), 5'($urandom));
            bus.ready_i = $urandom_range(0, 9) < 7;
            bus.flush_i = $urandom_range(0, 99) < 3;
            rst = $urandom_range(0, 199) != 0;
            cyc();
        end
        set_op(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        rst = 1'b1;
        repeat (12) cyc();
        chk("final_busy", {31'd0, bus.busy_o}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
